// File: rtl/msx_audio_pkg.sv
// Shared types and helpers for the MSX audio mixing path.
package msx_audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_SAT  = 2'd2
  } mix_state_e;

  // Q1.4 gain: 16 is unity.
  localparam int GAIN_UNITY = 16;
  localparam int GAIN_FRAC  = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/msx_audio_mixer_if.sv
// Sample/control bundle between the sound generators and the audio mixer.
interface msx_audio_mixer_if #(
  parameter int NCH = 4,
  parameter int IW  = 16,
  parameter int GW  = 5,
  parameter int OW  = 16
);
  logic                ce_i;
  logic [NCH*IW-1:0]   ch_i;
  logic [NCH-1:0]      ch_unsigned_i;
  logic [NCH*GW-1:0]   gain_i;
  logic [NCH-1:0]      mute_i;
  logic                clear_i;
  logic [OW-1:0]       audio_o;
  logic                valid_o;
  logic                busy_o;
  logic                clip_o;
  logic                overrun_o;

  modport master (
    output ce_i, ch_i, ch_unsigned_i, gain_i, mute_i, clear_i,
    input  audio_o, valid_o, busy_o, clip_o, overrun_o
  );

  modport slave (
    input  ce_i, ch_i, ch_unsigned_i, gain_i, mute_i, clear_i,
    output audio_o, valid_o, busy_o, clip_o, overrun_o
  );
endinterface

// File: rtl/msx_audio_sat.sv
// Combinational clamp of a wide signed value into OW bits, flagging when it clips.
module msx_audio_sat #(
  parameter int AW = 24,
  parameter int OW = 16
) (
  input  logic signed [AW-1:0] acc_i,
  output logic        [OW-1:0] sat_o,
  output logic                 clip_o
);

  localparam logic signed [AW-1:0] MAXV = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  always_comb begin
    sat_o  = acc_i[OW-1:0];
    clip_o = 1'b0;
    if (acc_i > MAXV) begin
      sat_o  = MAXV[OW-1:0];
      clip_o = 1'b1;
    end else if (acc_i < MINV) begin
      sat_o  = MINV[OW-1:0];
      clip_o = 1'b1;
    end
  end

endmodule

// File: rtl/msx_audio_mixer.sv
// Time-multiplexed N-channel mixer: one gain MAC per cycle, then clamp to OW.
module msx_audio_mixer
  import msx_audio_pkg::*;
#(
  parameter int NCH = 4,
  parameter int IW  = 16,
  parameter int GW  = 5,
  parameter int OW  = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  msx_audio_mixer_if.slave bus
);

  localparam int AW   = IW + GW + clog2(NCH) + 1;
  localparam int PW   = IW + GW + 1;
  localparam int IDXW = (clog2(NCH) > 0) ? clog2(NCH) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCH - 1);

  mix_state_e              state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [NCH*IW-1:0]       ch_q, ch_d;
  logic [NCH-1:0]          uns_q, uns_d;
  logic [NCH*GW-1:0]       gain_q, gain_d;
  logic [NCH-1:0]          mute_q, mute_d;
  logic [OW-1:0]           audio_q, audio_d;
  logic                    valid_q, valid_d;
  logic                    clip_q, clip_d;
  logic                    ovr_q, ovr_d;
  logic                    clip_set, ovr_set;

  logic [IW-1:0]           samp;
  logic [GW-1:0]           gain;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    term;
  logic [OW-1:0]           sat_y;
  logic                    sat_clip;

  // Single shared multiplier working on the snapshot of the selected channel.
  always_comb begin
    samp = ch_q[int'(idx_q)*IW +: IW];
    gain = gain_q[int'(idx_q)*GW +: GW];
    if (uns_q[idx_q]) samp[IW-1] = ~samp[IW-1];
    prod = PW'($signed(samp)) * PW'($signed({1'b0, gain}));
    term = AW'(prod) >>> GAIN_FRAC;
    if (mute_q[idx_q]) term = '0;
  end

  msx_audio_sat #(.AW(AW), .OW(OW)) u_sat (
    .acc_i  (acc_q),
    .sat_o  (sat_y),
    .clip_o (sat_clip)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    ch_d     = ch_q;
    uns_d    = uns_q;
    gain_d   = gain_q;
    mute_d   = mute_q;
    audio_d  = audio_q;
    valid_d  = 1'b0;
    clip_set = 1'b0;
    ovr_set  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A strobe landing on the result cycle is still treated as busy.
        if (bus.ce_i && valid_q) begin
          ovr_set = 1'b1;
        end else if (bus.ce_i) begin
          ch_d    = bus.ch_i;
          uns_d   = bus.ch_unsigned_i;
          gain_d  = bus.gain_i;
          mute_d  = bus.mute_i;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        ovr_set = bus.ce_i;
        acc_d   = acc_q + term;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST) state_d = ST_SAT;
      end
      ST_SAT: begin
        ovr_set  = bus.ce_i;
        audio_d  = sat_y;
        valid_d  = 1'b1;
        clip_set = sat_clip;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    clip_d = clip_set | (clip_q & ~bus.clear_i);
    ovr_d  = ovr_set  | (ovr_q  & ~bus.clear_i);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      ch_q    <= '0;
      uns_q   <= '0;
      gain_q  <= '0;
      mute_q  <= '0;
      audio_q <= '0;
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      ch_q    <= ch_d;
      uns_q   <= uns_d;
      gain_q  <= gain_d;
      mute_q  <= mute_d;
      audio_q <= audio_d;
      valid_q <= valid_d;
      clip_q  <= clip_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.audio_o   = audio_q;
  assign bus.valid_o   = valid_q;
  assign bus.busy_o    = (state_q != ST_IDLE);
  assign bus.clip_o    = clip_q;
  assign bus.overrun_o = ovr_q;

endmodule

// File: tb/tb_msx_audio_mixer.sv
// Self-checking bench for msx_audio_mixer: directed table, random mixes vs. arithmetic model, corner sequences.
module tb_msx_audio_mixer;

  localparam int NCH = 4, IW = 16, GW = 5, OW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  msx_audio_mixer_if #(.NCH(NCH), .IW(IW), .GW(GW), .OW(OW)) bus ();

  msx_audio_mixer #(.NCH(NCH), .IW(IW), .GW(GW), .OW(OW)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic [63:0] ch;
    logic [3:0]  uns;
    logic [19:0] gain;
    logic [3:0]  mute;
    logic [15:0] exp_audio;
    logic        exp_clip;
  } vec_t;

  vec_t tv[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pc(input int c0, input int c1, input int c2, input int c3);
    return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endfunction

  function automatic logic [19:0] pg(input int g0, input int g1, input int g2, input int g3);
    return {5'(g3), 5'(g2), 5'(g1), 5'(g0)};
  endfunction

  // Reference: convert, scale by gain/16 with floor, sum, clamp.
  function automatic logic [15:0] model(input logic [63:0] ch, input logic [3:0] uns,
                                        input logic [19:0] gain, input logic [3:0] mute,
                                        output logic clip);
    longint sum, p, t;
    int s, g;
    logic [15:0] v;
    sum = 0;
    for (int k = 0; k < NCH; k++) begin
      v = ch[k*16 +: 16];
      s = int'(v);
      if (uns[k]) s = s - 32768;
      else if (s >= 32768) s = s - 65536;
      g = int'(gain[k*5 +: 5]);
      p = longint'(s) * longint'(g);
      t = (p - (((p % 16) + 16) % 16)) / 16;
      if (!mute[k]) sum += t;
    end
    clip = 1'b0;
    if (sum > 32767)       begin sum = 32767;  clip = 1'b1; end
    else if (sum < -32768) begin sum = -32768; clip = 1'b1; end
    return 16'(sum);
  endfunction

  task automatic drive(input logic [63:0] ch, input logic [3:0] uns,
                       input logic [19:0] gain, input logic [3:0] mute);
    bus.ch_i = ch; bus.ch_unsigned_i = uns; bus.gain_i = gain; bus.mute_i = mute;
  endtask

  // Clears flags, strobes once, then waits (bounded) for valid; ends in the valid cycle.
  task automatic run_mix(input logic [63:0] ch, input logic [3:0] uns,
                         input logic [19:0] gain, input logic [3:0] mute,
                         output logic [15:0] aud, output int lat, output int bcnt);
    bus.clear_i = 1'b1;
    @(posedge clk); #1;
    bus.clear_i = 1'b0;
    drive(ch, uns, gain, mute);
    bus.ce_i = 1'b1;
    @(posedge clk); #1;
    bus.ce_i = 1'b0;
    lat = -1; bcnt = 0; aud = '0;
    for (int n = 0; n < 20; n++) begin
      if (bus.valid_o) begin
        lat = n; aud = bus.audio_o;
        break;
      end
      if (bus.busy_o) bcnt++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [15:0] aud, exp_a;
    logic        exp_c;
    int          lat, bcnt, nvalid;
    logic [63:0] rch;
    logic [19:0] rg;
    logic [3:0]  ru, rm;

    tv[0] = '{pc(16'h1234, 0, 0, 0), 4'b0000, pg(16, 0, 0, 0), 4'b0000, 16'h1234, 1'b0};
    tv[1] = '{pc(0, 16'h8000, 0, 0), 4'b0010, pg(0, 16, 0, 0), 4'b1101, 16'h0000, 1'b0};
    tv[2] = '{pc(0, 16'hFFFF, 0, 0), 4'b0010, pg(0, 16, 0, 0), 4'b1101, 16'h7FFF, 1'b0};
    tv[3] = '{pc(16'h6000, 16'h6000, 16'h6000, 16'h6000), 4'b0000, pg(16, 16, 16, 16), 4'b0000, 16'h7FFF, 1'b1};
    tv[4] = '{pc(16'hA000, 16'hA000, 16'hA000, 16'hA000), 4'b0000, pg(16, 16, 16, 16), 4'b0000, 16'h8000, 1'b1};
    tv[5] = '{pc(16'hFFFD, 0, 0, 0), 4'b0000, pg(8, 0, 0, 0), 4'b0000, 16'hFFFE, 1'b0};
    tv[6] = '{pc(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 4'b0000, pg(31, 31, 31, 31), 4'b1111, 16'h0000, 1'b0};
    tv[7] = '{pc(16'h1000, 0, 0, 0), 4'b0000, pg(31, 0, 0, 0), 4'b0000, 16'h1F00, 1'b0};
    tv[8] = '{pc(16'h0100, 16'hFF00, 16'h8100, 16'h0010), 4'b0100, pg(16, 16, 8, 31), 4'b0000, 16'h009F, 1'b0};

    bus.ce_i = 1'b0; bus.clear_i = 1'b0;
    drive('0, '0, '0, '0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset audio", 32'(bus.audio_o), 32'h0);
    check("reset valid", 32'(bus.valid_o), 32'h0);
    check("reset busy", 32'(bus.busy_o), 32'h0);
    check("reset clip", 32'(bus.clip_o), 32'h0);
    check("reset overrun", 32'(bus.overrun_o), 32'h0);
    rst_n = 1'b1;

    // Directed table
    foreach (tv[i]) begin
      run_mix(tv[i].ch, tv[i].uns, tv[i].gain, tv[i].mute, aud, lat, bcnt);
      check($sformatf("vec%0d audio", i), 32'(aud), 32'(tv[i].exp_audio));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd5);
      check($sformatf("vec%0d busy cycles", i), 32'(bcnt), 32'd5);
      check($sformatf("vec%0d clip", i), 32'(bus.clip_o), 32'(tv[i].exp_clip));
    end

    // Random mixes against the model
    for (int r = 0; r < 40; r++) begin
      rch = {$urandom(), $urandom()};
      rg  = 20'($urandom());
      ru  = 4'($urandom());
      rm  = 4'($urandom_range(0, 15)) & 4'($urandom());
      exp_a = model(rch, ru, rg, rm, exp_c);
      run_mix(rch, ru, rg, rm, aud, lat, bcnt);
      check($sformatf("rand%0d audio", r), 32'(aud), 32'(exp_a));
      check($sformatf("rand%0d clip", r), 32'(bus.clip_o), 32'(exp_c));
      check($sformatf("rand%0d latency", r), 32'(lat), 32'd5);
    end

    // Overrun: second strobe 3 cycles in, inputs scrambled mid-mix
    bus.clear_i = 1'b1; @(posedge clk); #1; bus.clear_i = 1'b0;
    drive(pc(16'h1234, 0, 0, 0), 4'b0000, pg(16, 0, 0, 0), 4'b0000);
    bus.ce_i = 1'b1; @(posedge clk); #1; bus.ce_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.ce_i = 1'b1;
    drive(pc(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 4'b1111, pg(31, 31, 31, 31), 4'b0000);
    @(posedge clk); #1; bus.ce_i = 1'b0;
    nvalid = 0; aud = '0;
    for (int n = 3; n < 16; n++) begin
      if (bus.valid_o) begin nvalid++; aud = bus.audio_o; end
      @(posedge clk); #1;
    end
    check("overrun valid count", 32'(nvalid), 32'd1);
    check("overrun audio snapshot", 32'(aud), 32'h1234);
    check("overrun flag", 32'(bus.overrun_o), 32'h1);
    bus.clear_i = 1'b1; @(posedge clk); #1; bus.clear_i = 1'b0;
    check("overrun cleared", 32'(bus.overrun_o), 32'h0);

    // Set beats clear in the same cycle
    bus.ce_i = 1'b1; @(posedge clk); #1; bus.ce_i = 1'b0;
    bus.ce_i = 1'b1; bus.clear_i = 1'b1;
    @(posedge clk); #1;
    bus.ce_i = 1'b0; bus.clear_i = 1'b0;
    check("set wins over clear", 32'(bus.overrun_o), 32'h1);
    repeat (8) @(posedge clk);
    #1;

    // Strobe coinciding with valid is dropped and flagged
    run_mix(pc(16'h0042, 0, 0, 0), 4'b0000, pg(16, 0, 0, 0), 4'b0000, aud, lat, bcnt);
    check("valid-cycle mix audio", 32'(aud), 32'h0042);
    bus.ce_i = 1'b1; @(posedge clk); #1; bus.ce_i = 1'b0;
    check("valid-cycle ce overrun", 32'(bus.overrun_o), 32'h1);
    check("valid-cycle ce not accepted", 32'(bus.busy_o), 32'h0);

    // Reset mid-mix: clip set beforehand so the async clear is visible
    run_mix(pc(16'h6000, 16'h6000, 16'h6000, 16'h6000), 4'b0000, pg(16, 16, 16, 16), 4'b0000, aud, lat, bcnt);
    @(posedge clk); #1;
    bus.ce_i = 1'b1; @(posedge clk); #1; bus.ce_i = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midreset audio", 32'(bus.audio_o), 32'h0);
    check("midreset busy", 32'(bus.busy_o), 32'h0);
    check("midreset clip", 32'(bus.clip_o), 32'h0);
    check("midreset valid", 32'(bus.valid_o), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nvalid = 0;
    for (int n = 0; n < 10; n++) begin
      if (bus.valid_o) nvalid++;
      @(posedge clk); #1;
    end
    check("no valid after reset", 32'(nvalid), 32'd0);
    run_mix(pc(16'h0100, 16'h0200, 0, 0), 4'b0000, pg(16, 8, 0, 0), 4'b0000, aud, lat, bcnt);
    check("post-reset audio", 32'(aud), 32'h0200);
    check("post-reset latency", 32'(lat), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msx_audio_mixer.md
# msx_audio_mixer

Parametrised, time-multiplexed audio mixer that takes the MSX core's N sound sources and produces one saturated signed sample per sample strobe. Typical sources are PSG, key click, cassette monitor and slot sound such as SCC or FM. Each channel gets per-channel gain, offset-binary conversion and muting. The block replaces the fixed two-source combinational mix and compression lookup at the top level of the MSX core. It sits between the sound generators and the core's `audio` output.

## Interface
Parameters:
- `NCH`, 4, number of input channels (1..16).
- `IW`, 16, input sample width per channel.
- `GW`, 5, gain width per channel; gain is unsigned Q1.4, so 16 = unity and 31 = 1.9375.
- `OW`, 16, output sample width (OW ≤ IW+GW).

Ports:
- `clk_i` in 1: system clock.
- `reset_n_i` in 1: **asynchronous, active-low reset; single clock domain (`clk_i`)**.
- `ce_i` in 1: sample strobe, one-cycle pulse that starts a mix.
- `ch_i` in NCH*IW: channel samples; channel k occupies bits [k*IW +: IW].
- `ch_unsigned_i` in NCH: 1 means channel k is offset binary and must be converted.
- `gain_i` in NCH*GW: per-channel gains, packed the same way as `ch_i`.
- `mute_i` in NCH: 1 forces channel k's contribution to 0.
- `clear_i` in 1: synchronous clear of the sticky flags.
- `audio_o` out OW: signed mixed sample, held between updates.
- `valid_o` out 1: one-cycle pulse when `audio_o` updates.
- `busy_o` out 1: high from the cycle after an accepted `ce_i` until the cycle `valid_o` is high.
- `clip_o` out 1: sticky; set when any output saturated.
- `overrun_o` out 1: sticky; set when `ce_i` arrives while busy.

## Operation
- States: IDLE, ACC, SAT.
- IDLE:
  - On `ce_i`, snapshot `ch_i`, `ch_unsigned_i`, `gain_i` and `mute_i` into holding registers.
  - Clear the accumulator, set the channel index to 0 and go to ACC.
- ACC: one channel per cycle, for k = 0..NCH-1.
  - Conversion: if `ch_unsigned_i[k]` is 1, invert the sample MSB (offset binary to two's complement). Otherwise treat the sample as signed.
  - Term = (sample × gain) >>> 4, arithmetic shift, truncation toward −∞.
  - Muted channels add 0.
  - Accumulator width is IW+GW+clog2(NCH)+1 bits; it never wraps.
  - After channel NCH-1, go to SAT.
- SAT:
  - Clamp the accumulator to [−2^(OW-1), 2^(OW-1)−1].
  - Register the result into `audio_o` and pulse `valid_o`.
  - If the clamp was active, set `clip_o`.
  - Return to IDLE.
- `ce_i` while busy: the request is dropped, `overrun_o` is set and the mix in progress is unaffected.
- `ce_i` in the same cycle as `valid_o`: dropped, and counts as an overrun.
- `clear_i` clears `clip_o` and `overrun_o`. If a set event occurs in the same cycle, the set wins.
- Inputs changing during ACC have no effect, because the snapshot is used.
- Reset values: `audio_o` = 0, `valid_o` = 0, `busy_o` = 0, `clip_o` = 0, `overrun_o` = 0; state = IDLE.
- Reset asserted mid-mix aborts the mix; no `valid_o` is produced.

## Timing
- Latency: `ce_i` sampled high at edge E0 gives `valid_o` high and the new `audio_o` in the cycle after edge E0+NCH+1. That is NCH+1 cycles of busy (ACC×NCH, then SAT).
- Minimum strobe spacing without overrun is NCH+2 cycles.
- At 3.58 MHz strobe rates from a 21 MHz+ `clk_i`, overrun never occurs for NCH ≤ 4.
- One multiplier, IW×GW; no combinational path from inputs to outputs.

## Structure
- Shared package `msx_audio_pkg`: state enum (IDLE/ACC/SAT), the Q1.4 unity constant (16) and a clog2 helper function.
- Sub-module `msx_audio_sat`: combinational parametrised clamp from the accumulator width to OW, with a clip flag. It is reused by the slot sound path.
- Everything else (FSM, index counter, snapshot, MAC) lives in `msx_audio_mixer`.

## Test plan
1. Unity pass-through:
   - Stimulus: NCH=4; ch0 = 0x1234, gains {16,0,0,0}; `ce_i` pulse.
   - Response: `audio_o` = 0x1234, `valid_o` exactly 6 cycles after `ce_i`, `busy_o` high 5 cycles.
2. Unsigned conversion:
   - Stimulus: ch1 = 0x8000 with `ch_unsigned_i[1]`=1, gain 16, others muted.
   - Response: `audio_o` = 0x0000. Then ch1 = 0xFFFF gives 0x7FFF.
3. Saturation:
   - Stimulus: all four channels 0x6000 at gain 16.
   - Response: `audio_o` = 0x7FFF and `clip_o` = 1. All four at 0xA000 gives 0x8000.
4. Negative gain truncation:
   - Stimulus: ch0 = −3 (0xFFFD), gain 8.
   - Response: `audio_o` = 0xFFFE (−1.5 floors to −2).
5. Overrun:
   - Stimulus: second `ce_i` 3 cycles after the first.
   - Response: one `valid_o` only, `overrun_o` = 1. `clear_i` drops it to 0 the next cycle.
6. Reset mid-mix:
   - Stimulus: assert `reset_n_i` low during ACC.
   - Response: all outputs 0 immediately (asynchronous); no `valid_o` after release; the next `ce_i` mixes normally.
